// File: rtl/non_max_suppression.sv
// Canny non-maximum suppression: keeps the centre of a 3x3 magnitude window
// only when it is a local maximum along the centre pixel's gradient direction.
// Latency 1 cycle; one window per cycle; no backpressure (windows are never stalled).
//
// Optional build macro: NMS_THRESH_EN -- when defined, kept pixels whose centre
// magnitude is below LOW_THRESH are also zeroed.
//
// Ports:
//   clk, rst                       clock and synchronous active-high reset
//   Gradiant_Magnitude_Data        9 x MAG_W magnitude window, item k at [k*MAG_W +: MAG_W]
//   Direction_Data                 9 x 2-bit direction window, item k at [k*2 +: 2]
//   Gradiant_Magnitude_in_valid    magnitude window valid
//   Direction_Data_in_valid        direction window valid
//   NMS_pixel                      suppressed magnitude (held when not valid)
//   NMS_Direction_Data             centre direction (held when not valid)
//   NMS_Pixels_out_valid           one-cycle pulse per accepted window
//   frame_end                      high with the last output of a frame
//   valid_mismatch                 sticky: one input valid seen without the other

module non_max_suppression #(
    parameter int MAG_W      = 11,
    parameter int FRAME_W    = 506,
    parameter int FRAME_H    = 506,
    parameter int LOW_THRESH = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [9*MAG_W-1:0] Gradiant_Magnitude_Data,
    input  logic [17:0]        Direction_Data,
    input  logic               Gradiant_Magnitude_in_valid,
    input  logic               Direction_Data_in_valid,
    output logic [MAG_W-1:0]   NMS_pixel,
    output logic [1:0]         NMS_Direction_Data,
    output logic               NMS_Pixels_out_valid,
    output logic               frame_end,
    output logic               valid_mismatch
);

    localparam int COL_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam int ROW_W = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(FRAME_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FRAME_H - 1);
    localparam logic [MAG_W-1:0] LOW_T    = MAG_W'(LOW_THRESH);

    logic [MAG_W-1:0] r_pixel;
    logic [1:0]       r_dir;
    logic             r_vld;
    logic             r_frame_end;
    logic             r_mismatch;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;

    logic             w_accept;
    logic             w_mismatch;
    logic [1:0]       w_dir;
    logic [MAG_W-1:0] w_centre;
    logic [MAG_W-1:0] w_nbr_a;
    logic [MAG_W-1:0] w_nbr_b;
    logic             w_floor_ok;
    logic             w_keep;
    logic             w_col_wrap;
    logic             w_row_wrap;

    assign w_accept   = Gradiant_Magnitude_in_valid & Direction_Data_in_valid;
    assign w_mismatch = Gradiant_Magnitude_in_valid ^ Direction_Data_in_valid;

    assign w_dir    = Direction_Data[4*2 +: 2];
    assign w_centre = Gradiant_Magnitude_Data[4*MAG_W +: MAG_W];

    // Neighbour pair lies on the line through the centre along the gradient.
    always_comb begin
        w_nbr_a = '0;
        w_nbr_b = '0;
        case (w_dir)
            2'd0: begin
                w_nbr_a = Gradiant_Magnitude_Data[3*MAG_W +: MAG_W];
                w_nbr_b = Gradiant_Magnitude_Data[5*MAG_W +: MAG_W];
            end
            2'd1: begin
                w_nbr_a = Gradiant_Magnitude_Data[2*MAG_W +: MAG_W];
                w_nbr_b = Gradiant_Magnitude_Data[6*MAG_W +: MAG_W];
            end
            2'd2: begin
                w_nbr_a = Gradiant_Magnitude_Data[1*MAG_W +: MAG_W];
                w_nbr_b = Gradiant_Magnitude_Data[7*MAG_W +: MAG_W];
            end
            default: begin
                w_nbr_a = Gradiant_Magnitude_Data[0*MAG_W +: MAG_W];
                w_nbr_b = Gradiant_Magnitude_Data[8*MAG_W +: MAG_W];
            end
        endcase
    end

`ifdef NMS_THRESH_EN
    assign w_floor_ok = (w_centre >= LOW_T);
`else
    // Floor disabled; the term keeps LOW_THRESH referenced so both builds
    // share one parameter list.
    assign w_floor_ok = 1'b1 | (w_centre >= LOW_T);
`endif

    // Ties keep the pixel, so >= on both sides.
    assign w_keep = (w_centre >= w_nbr_a) && (w_centre >= w_nbr_b) && w_floor_ok;

    assign w_col_wrap = (r_col == COL_LAST);
    assign w_row_wrap = (r_row == ROW_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pixel     <= '0;
            r_dir       <= '0;
            r_vld       <= 1'b0;
            r_frame_end <= 1'b0;
            r_mismatch  <= 1'b0;
            r_col       <= '0;
            r_row       <= '0;
        end else begin
            r_vld       <= w_accept;
            r_frame_end <= 1'b0;
            if (w_mismatch) begin
                r_mismatch <= 1'b1;
            end
            if (w_accept) begin
                r_pixel <= w_keep ? w_centre : '0;
                r_dir   <= w_dir;
                if (w_col_wrap) begin
                    r_col <= '0;
                    if (w_row_wrap) begin
                        r_row       <= '0;
                        r_frame_end <= 1'b1;
                    end else begin
                        r_row <= r_row + ROW_W'(1);
                    end
                end else begin
                    r_col <= r_col + COL_W'(1);
                end
            end
        end
    end

    assign NMS_pixel            = r_pixel;
    assign NMS_Direction_Data   = r_dir;
    assign NMS_Pixels_out_valid = r_vld;
    assign frame_end            = r_frame_end;
    assign valid_mismatch       = r_mismatch;

endmodule

// File: tb/tb_non_max_suppression.sv
module tb_non_max_suppression;

    localparam int MAG_W = 11;

    logic               clk = 1'b0;
    logic               rst;
    logic [9*MAG_W-1:0] mag;
    logic [17:0]        dir;
    logic               mag_vld;
    logic               dir_vld;
    logic [MAG_W-1:0]   nms_pixel;
    logic [1:0]         nms_dir;
    logic               nms_vld;
    logic               frame_end;
    logic               valid_mismatch;

    int checks = 0;
    int errors = 0;

    logic [MAG_W-1:0] win [9];

    non_max_suppression #(
        .MAG_W      (MAG_W),
        .FRAME_W    (4),
        .FRAME_H    (2),
        .LOW_THRESH (30)
    ) dut (
        .clk                         (clk),
        .rst                         (rst),
        .Gradiant_Magnitude_Data     (mag),
        .Direction_Data              (dir),
        .Gradiant_Magnitude_in_valid (mag_vld),
        .Direction_Data_in_valid     (dir_vld),
        .NMS_pixel                   (nms_pixel),
        .NMS_Direction_Data          (nms_dir),
        .NMS_Pixels_out_valid        (nms_vld),
        .frame_end                   (frame_end),
        .valid_mismatch              (valid_mismatch)
    );

    always #5 clk = ~clk;

    task automatic clear_win();
        for (int k = 0; k < 9; k++) win[k] = '0;
    endtask

    // Non-centre direction items carry a different code so the DUT must use item 4.
    task automatic load(input logic [1:0] d);
        for (int k = 0; k < 9; k++) begin
            mag[k*MAG_W +: MAG_W] = win[k];
            dir[k*2 +: 2]         = (k == 4) ? d : d + 2'd1;
        end
    endtask

    // Presents one window for one cycle; returns at the negedge after the
    // accepting posedge, where that window's result is visible.
    task automatic send(input logic [1:0] d, input logic vm, input logic vd);
        @(negedge clk);
        load(d);
        mag_vld = vm;
        dir_vld = vd;
        @(negedge clk);
        mag_vld = 1'b0;
        dir_vld = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; mag_vld = 1'b0; dir_vld = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mag_vld = 1'b0; dir_vld = 1'b0; mag = '0; dir = '0;
        repeat (3) @(negedge clk);
        checks++; if (nms_pixel !== 11'd0) begin errors++; $display("FAIL reset_pixel: got %0d expected 0", nms_pixel); end
        checks++; if (nms_dir !== 2'd0) begin errors++; $display("FAIL reset_dir: got %0d expected 0", nms_dir); end
        checks++; if (nms_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %0b expected 0", nms_vld); end
        checks++; if (frame_end !== 1'b0) begin errors++; $display("FAIL reset_frame_end: got %0b expected 0", frame_end); end
        checks++; if (valid_mismatch !== 1'b0) begin errors++; $display("FAIL reset_mismatch: got %0b expected 0", valid_mismatch); end
        rst = 1'b0;
    endtask

    task automatic test_horizontal();
        do_reset();
        clear_win(); win[3] = 11'd10; win[4] = 11'd50; win[5] = 11'd20;
        send(2'd0, 1'b1, 1'b1);
        checks++; if (nms_vld !== 1'b1) begin errors++; $display("FAIL horiz_vld: got %0b expected 1", nms_vld); end
        checks++; if (nms_pixel !== 11'd50) begin errors++; $display("FAIL horiz_keep: got %0d expected 50", nms_pixel); end
        checks++; if (nms_dir !== 2'd0) begin errors++; $display("FAIL horiz_dir: got %0d expected 0", nms_dir); end
        @(negedge clk);
        checks++; if (nms_vld !== 1'b0) begin errors++; $display("FAIL horiz_vld_pulse: got %0b expected 0", nms_vld); end
        checks++; if (nms_pixel !== 11'd50) begin errors++; $display("FAIL horiz_hold: got %0d expected 50", nms_pixel); end
        win[5] = 11'd60;
        send(2'd0, 1'b1, 1'b1);
        checks++; if (nms_pixel !== 11'd0) begin errors++; $display("FAIL horiz_suppress: got %0d expected 0", nms_pixel); end
        checks++; if (nms_dir !== 2'd0) begin errors++; $display("FAIL horiz_suppress_dir: got %0d expected 0", nms_dir); end
    endtask

    task automatic test_directions();
        int pa [4];
        int pb [4];
        logic [1:0] dd;
        pa = '{3, 2, 1, 0};
        pb = '{5, 6, 7, 8};
        for (int d = 1; d < 4; d++) begin
            dd = 2'(d);
            clear_win(); win[4] = 11'd100; win[pa[d]] = 11'd200; win[pb[d]] = 11'd200;
            send(dd, 1'b1, 1'b1);
            checks++; if (nms_pixel !== 11'd0) begin errors++; $display("FAIL dir%0d_on_axis: got %0d expected 0", d, nms_pixel); end
            checks++; if (nms_dir !== dd) begin errors++; $display("FAIL dir%0d_dir: got %0d expected %0d", d, nms_dir, d); end
            // Pair moved to the next axis round, which this direction ignores.
            clear_win(); win[4] = 11'd100; win[pa[(d+1)%4]] = 11'd200; win[pb[(d+1)%4]] = 11'd200;
            send(dd, 1'b1, 1'b1);
            checks++; if (nms_pixel !== 11'd100) begin errors++; $display("FAIL dir%0d_off_axis: got %0d expected 100", d, nms_pixel); end
        end
    endtask

    task automatic test_tie();
        clear_win(); win[3] = 11'd2047; win[4] = 11'd2047; win[5] = 11'd2047;
        send(2'd0, 1'b1, 1'b1);
        checks++; if (nms_pixel !== 11'd2047) begin errors++; $display("FAIL tie_d0: got %0d expected 2047", nms_pixel); end
        clear_win(); win[0] = 11'd2047; win[4] = 11'd2047; win[8] = 11'd2047;
        send(2'd3, 1'b1, 1'b1);
        checks++; if (nms_pixel !== 11'd2047) begin errors++; $display("FAIL tie_d3: got %0d expected 2047", nms_pixel); end
    endtask

    // 16 windows back to back over a 4x2 frame: frame_end on outputs 8 and 16.
    task automatic test_back_to_back();
        logic exp_fe;
        do_reset();
        clear_win();
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            if (i > 0) begin
                exp_fe = (i == 8) || (i == 16);
                checks++; if (nms_vld !== 1'b1) begin errors++; $display("FAIL b2b_vld[%0d]: got %0b expected 1", i, nms_vld); end
                checks++; if (nms_pixel !== 11'(i)) begin errors++; $display("FAIL b2b_pixel[%0d]: got %0d expected %0d", i, nms_pixel, i); end
                checks++; if (frame_end !== exp_fe) begin errors++; $display("FAIL b2b_frame_end[%0d]: got %0b expected %0b", i, frame_end, exp_fe); end
            end
            if (i < 16) begin
                win[4] = 11'(i + 1);
                load(2'd0);
                mag_vld = 1'b1; dir_vld = 1'b1;
            end else begin
                mag_vld = 1'b0; dir_vld = 1'b0;
            end
        end
        @(negedge clk);
        checks++; if (frame_end !== 1'b0) begin errors++; $display("FAIL b2b_frame_end_idle: got %0b expected 0", frame_end); end
    endtask

    task automatic test_mismatch();
        do_reset();
        clear_win(); win[4] = 11'd5;
        for (int i = 0; i < 7; i++) send(2'd0, 1'b1, 1'b1);
        send(2'd0, 1'b1, 1'b0);
        checks++; if (nms_vld !== 1'b0) begin errors++; $display("FAIL mm_no_output: got %0b expected 0", nms_vld); end
        checks++; if (valid_mismatch !== 1'b1) begin errors++; $display("FAIL mm_flag: got %0b expected 1", valid_mismatch); end
        send(2'd0, 1'b0, 1'b1);
        checks++; if (nms_vld !== 1'b0) begin errors++; $display("FAIL mm_no_output_dir: got %0b expected 0", nms_vld); end
        // Dropped windows did not advance the counters: this is the 8th output.
        send(2'd0, 1'b1, 1'b1);
        checks++; if (frame_end !== 1'b1) begin errors++; $display("FAIL mm_no_advance: got frame_end %0b expected 1", frame_end); end
        checks++; if (valid_mismatch !== 1'b1) begin errors++; $display("FAIL mm_sticky: got %0b expected 1", valid_mismatch); end
        do_reset();
        @(negedge clk);
        checks++; if (valid_mismatch !== 1'b0) begin errors++; $display("FAIL mm_cleared: got %0b expected 0", valid_mismatch); end
    endtask

    task automatic test_reset_wins();
        send(2'd2, 1'b1, 1'b1);
        clear_win(); win[4] = 11'd77;
        @(negedge clk);
        load(2'd1);
        mag_vld = 1'b1; dir_vld = 1'b1; rst = 1'b1;
        @(negedge clk);
        mag_vld = 1'b0; dir_vld = 1'b0; rst = 1'b0;
        checks++; if (nms_vld !== 1'b0) begin errors++; $display("FAIL rstwin_vld: got %0b expected 0", nms_vld); end
        checks++; if (nms_pixel !== 11'd0) begin errors++; $display("FAIL rstwin_pixel: got %0d expected 0", nms_pixel); end
        checks++; if (nms_dir !== 2'd0) begin errors++; $display("FAIL rstwin_dir: got %0d expected 0", nms_dir); end
    endtask

    task automatic test_threshold();
        clear_win(); win[4] = 11'd25; win[3] = 11'd1; win[5] = 11'd2;
        send(2'd0, 1'b1, 1'b1);
`ifdef NMS_THRESH_EN
        checks++; if (nms_pixel !== 11'd0) begin errors++; $display("FAIL thresh_below: got %0d expected 0", nms_pixel); end
        win[4] = 11'd30;
        send(2'd0, 1'b1, 1'b1);
        checks++; if (nms_pixel !== 11'd30) begin errors++; $display("FAIL thresh_at: got %0d expected 30", nms_pixel); end
`else
        checks++; if (nms_pixel !== 11'd25) begin errors++; $display("FAIL thresh_ignored: got %0d expected 25", nms_pixel); end
`endif
        checks++; if (nms_dir !== 2'd0) begin errors++; $display("FAIL thresh_dir: got %0d expected 0", nms_dir); end
    endtask

    initial begin
        test_reset();
        test_horizontal();
        test_directions();
        test_tie();
        test_back_to_back();
        test_mismatch();
        test_reset_wins();
        test_threshold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
